epsilon_greedy_selector: RTL and testbench
==========================================

# epsilon_greedy_selector

Epsilon-greedy action-selection stage that sits directly upstream of the Q-learning accelerator. On each request it either explores by picking a pseudo-random action or exploits by scanning the 15 Q-values of the current state through a synchronous Q-table read port and returning the arg-max. The chosen action and its Q-value are presented on a valid/ready output for the update stage to consume.

## Interface

Parameters:
- `Q_W`, 16, Q-value width; two's-complement signed, Q8.8.
- `S_W`, 6, state index width.
- `LFSR_SEED`, 16'hACE1, LFSR value loaded on reset; must be non-zero.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a selection; accepted only in IDLE.
- `state`  in  S_W  current state; latched on accept.
- `epsilon`  in  16  exploration threshold, unsigned; latched on accept.
- `q_rd_en`  out  1  Q-table read strobe.
- `q_rd_state`  out  S_W  read address (latched state).
- `q_rd_action`  out  4  action being read, 1..15.
- `q_rd_data`  in  Q_W  read data; valid exactly 1 cycle after `q_rd_en`.
- `busy`  out  1  high in every state except IDLE.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_action`  out  4  selected action, 1..15; 0 is never produced.
- `out_q`  out  Q_W  Q-value of the selected action when exploiting; 0 when exploring.
- `out_explored`  out  1  1 = random action, 0 = greedy action.

## Operation

- States: IDLE, SCAN, DRAIN, HOLD.
- LFSR: 16-bit Galois, right shift, toggle mask 16'hB400 applied when the shifted-out LSB is 1.
  - Advances exactly once per accepted `start`.
  - The decision uses the value held before the advance.
- IDLE with `start`=1: latch `state` and `epsilon`, sample LFSR value L.
  - If L < epsilon (unsigned): explore. `out_action` = L[15:12], or 1 if L[15:12]==0. `out_q`=0, `out_explored`=1. Go to HOLD.
  - Otherwise: exploit. Go to SCAN.
- `epsilon`=0 never explores.
- SCAN:
  - Issue reads for actions 1..15, one per cycle, with `q_rd_en`=1.
  - Compare each returned `q_rd_data` signed against the running max.
  - Action 1 initialises the max.
  - Replace the max only on strictly greater, so ties resolve to the lowest action.
- DRAIN: one cycle to compare the action-15 data. Then load `out_action`/`out_q`, set `out_explored`=0, go to HOLD.
- HOLD: `out_valid`=1. Outputs are stable until `out_valid && out_ready`, then go to IDLE.
- `start` outside IDLE is ignored; it is neither queued nor does it advance the LFSR.
- `q_rd_en`=0 and `q_rd_action`=0 outside SCAN.

## Timing

- Reset values: `q_rd_en`=0, `q_rd_state`=0, `q_rd_action`=0, `busy`=0, `out_valid`=0, `out_action`=0, `out_q`=0, `out_explored`=0, LFSR=`LFSR_SEED`, state IDLE.
- `rst` in any state (including mid-SCAN or HOLD) aborts at the next edge. No partial result is emitted and the LFSR is reseeded.
- With `start` sampled at edge 0:
  - Explore: `out_valid`=1 from cycle 1. Latency 1.
  - Exploit: `q_rd_en`=1 in cycles 1..15 with `q_rd_action`=1..15. Data returns in cycles 2..16. `out_valid`=1 from cycle 17. Latency 17.
- The handshake completes in the cycle where `out_valid` and `out_ready` are both 1. `busy` falls the next cycle, and a new `start` is accepted from that cycle.
- `out_ready` is don't-care when `out_valid`=0.
- Back-to-back: minimum start-to-start spacing is 2 cycles (explore) or 18 cycles (exploit).

## Test plan

- Exploit: reset, `epsilon`=0, state 5, Q(a)=a*16'h0100 for a=1..15. Required: reads 1..15 in cycles 1..15, then `out_valid` at cycle 17 with action 15, `out_q`=16'h0F00, `out_explored`=0.
- Signed compare and ties: all Q=16'hFF00 (-1.0) except actions 4 and 9 = 16'h0080. Required: action 4, `out_q`=16'h0080.
- Explore: after reset, `epsilon`=16'hFFFF, `start`. Required: L=16'hACE1, action 10, `out_explored`=1, `out_valid` at cycle 1, no `q_rd_en`. A second request uses L=16'hE270 and returns action 14.
- Backpressure: hold `out_ready`=0 for 10 cycles during HOLD. Required: outputs stable. Pulsing `start` meanwhile has no effect, and the LFSR is unchanged afterwards.
- Reset mid-scan: assert `rst` at cycle 8 of a SCAN. Required: all outputs at reset values the next cycle, and no `out_valid`. The next explore request again yields L=16'hACE1.

Source files
------------

// File: rtl/epsilon_greedy_selector.sv
// Epsilon-greedy action selector: explores with a Galois LFSR draw or
// exploits by scanning Q(state, 1..15) through a 1-cycle-latency read port
// and returning the signed arg-max (ties go to the lowest action).
module epsilon_greedy_selector #(
    parameter int          Q_W       = 16,
    parameter int          S_W       = 6,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [S_W-1:0] state,
    input  logic [15:0]    epsilon,
    output logic           q_rd_en,
    output logic [S_W-1:0] q_rd_state,
    output logic [3:0]     q_rd_action,
    input  logic [Q_W-1:0] q_rd_data,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [3:0]     out_action,
    output logic [Q_W-1:0] out_q,
    output logic           out_explored
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, HOLD} fsm_e;

    fsm_e           fsm_q;
    logic [15:0]    lfsr_q;
    logic [15:0]    lfsr_d;
    logic           rd_en_q;
    logic [3:0]     rd_act_q;
    logic [S_W-1:0] st_q;
    // Read issued last cycle: its data is on q_rd_data this cycle.
    logic           pend_q;
    logic [3:0]     pend_act_q;
    logic [Q_W-1:0] max_q;
    logic [Q_W-1:0] max_d;
    logic [3:0]     max_act_q;
    logic [3:0]     max_act_d;
    logic           valid_q;
    logic [3:0]     act_q;
    logic [Q_W-1:0] oq_q;
    logic           expl_q;
    logic           take;
    logic [3:0]     explore_act;

    // Galois step, right shift, mask applied when the shifted-out bit is 1.
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Action 0 is reserved, so a zero top nibble maps to action 1.
    assign explore_act = (lfsr_q[15:12] == 4'd0) ? 4'd1 : lfsr_q[15:12];

    // Action 1 seeds the running max; later actions replace only on strictly greater.
    assign take      = pend_q && ((pend_act_q == 4'd1) ||
                                  ($signed(q_rd_data) > $signed(max_q)));
    assign max_d     = take ? q_rd_data  : max_q;
    assign max_act_d = take ? pend_act_q : max_act_q;

    assign q_rd_en      = rd_en_q;
    assign q_rd_action  = rd_act_q;
    assign q_rd_state   = st_q;
    assign busy         = (fsm_q != IDLE);
    assign out_valid    = valid_q;
    assign out_action   = act_q;
    assign out_q        = oq_q;
    assign out_explored = expl_q;

    // Control FSM, read sequencer, arg-max tracker and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= IDLE;
            lfsr_q     <= LFSR_SEED;
            rd_en_q    <= 1'b0;
            rd_act_q   <= 4'd0;
            st_q       <= '0;
            pend_q     <= 1'b0;
            pend_act_q <= 4'd0;
            max_q      <= '0;
            max_act_q  <= 4'd0;
            valid_q    <= 1'b0;
            act_q      <= 4'd0;
            oq_q       <= '0;
            expl_q     <= 1'b0;
        end else begin
            pend_q     <= rd_en_q;
            pend_act_q <= rd_act_q;
            max_q      <= max_d;
            max_act_q  <= max_act_d;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        st_q   <= state;
                        lfsr_q <= lfsr_d;
                        if (lfsr_q < epsilon) begin
                            act_q   <= explore_act;
                            oq_q    <= '0;
                            expl_q  <= 1'b1;
                            valid_q <= 1'b1;
                            fsm_q   <= HOLD;
                        end else begin
                            rd_en_q  <= 1'b1;
                            rd_act_q <= 4'd1;
                            fsm_q    <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (rd_act_q == 4'd15) begin
                        rd_en_q  <= 1'b0;
                        rd_act_q <= 4'd0;
                        fsm_q    <= DRAIN;
                    end else begin
                        rd_act_q <= rd_act_q + 4'd1;
                    end
                end
                DRAIN: begin
                    // Action-15 data is on the bus now; fold it in directly.
                    act_q   <= max_act_d;
                    oq_q    <= max_d;
                    expl_q  <= 1'b0;
                    valid_q <= 1'b1;
                    fsm_q   <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        fsm_q   <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_epsilon_greedy_selector.sv
// Directed bench for epsilon_greedy_selector with a 1-cycle Q-table model.
module tb_epsilon_greedy_selector;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [5:0]  state;
    logic [15:0] epsilon;
    logic        q_rd_en;
    logic [5:0]  q_rd_state;
    logic [3:0]  q_rd_action;
    logic [15:0] q_rd_data;
    logic        busy, out_valid, out_explored;
    logic [3:0]  out_action;
    logic [15:0] out_q;

    logic [15:0] qtab [0:15];
    int n_chk  = 0;
    int n_pass = 0;

    epsilon_greedy_selector #(.Q_W(16), .S_W(6), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .state(state), .epsilon(epsilon),
        .q_rd_en(q_rd_en), .q_rd_state(q_rd_state), .q_rd_action(q_rd_action),
        .q_rd_data(q_rd_data), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_action(out_action), .out_q(out_q),
        .out_explored(out_explored)
    );

    always #5 clk = ~clk;

    // Synchronous Q-table: data for a read appears one cycle later.
    always @(posedge clk) q_rd_data <= q_rd_en ? qtab[q_rd_action] : 16'h0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic chk_reset_vals();
        chk("rst_rd_en", q_rd_en, 0);
        chk("rst_rd_state", q_rd_state, 0);
        chk("rst_rd_act", q_rd_action, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_action", out_action, 0);
        chk("rst_q", out_q, 0);
        chk("rst_explored", out_explored, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
    endtask

    // Start pulse sampled at edge 0; returns at the negedge of cycle 1.
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_exploit(input logic [3:0] ea, input logic [15:0] eq);
        pulse_start();
        for (int k = 1; k <= 15; k++) begin
            chk("scan_rd_en", q_rd_en, 1);
            chk("scan_rd_act", q_rd_action, k);
            chk("scan_valid", out_valid, 0);
            if (k == 1) chk("scan_rd_state", q_rd_state, state);
            @(negedge clk);
        end
        chk("drain_rd_en", q_rd_en, 0);
        chk("drain_rd_act", q_rd_action, 0);
        chk("drain_valid", out_valid, 0);
        chk("drain_busy", busy, 1);
        @(negedge clk);
        chk("expl_valid", out_valid, 1);
        chk("expl_action", out_action, ea);
        chk("expl_q", out_q, eq);
        chk("expl_explored", out_explored, 0);
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        chk("expl_done_valid", out_valid, 0);
        chk("expl_done_busy", busy, 0);
    endtask

    // Explore request; holds the result for 'hold' cycles while pulsing start.
    task automatic run_explore(input logic [3:0] ea, input int hold);
        pulse_start();
        chk("xpl_valid", out_valid, 1);
        chk("xpl_action", out_action, ea);
        chk("xpl_q", out_q, 0);
        chk("xpl_explored", out_explored, 1);
        chk("xpl_rd_en", q_rd_en, 0);
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_action", out_action, ea);
            chk("hold_explored", out_explored, 1);
            chk("hold_rd_en", q_rd_en, 0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        chk("xpl_done_valid", out_valid, 0);
        chk("xpl_done_busy", busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; state = 6'd0; epsilon = 16'h0000;
        for (int a = 0; a < 16; a++) qtab[a] = 16'h0000;
        do_reset();

        // Monotonic Q: greedy pick is action 15.
        for (int a = 1; a < 16; a++) qtab[a] = 16'(a) << 8;
        state = 6'd5; epsilon = 16'h0000;
        run_exploit(4'd15, 16'h0F00);

        // Negative values and a tie between actions 4 and 9.
        for (int a = 1; a < 16; a++) qtab[a] = 16'hFF00;
        qtab[4] = 16'h0080; qtab[9] = 16'h0080;
        state = 6'd33;
        run_exploit(4'd4, 16'h0080);

        // Explore from the seed: ACE1 -> action 10, then E270 -> action 14.
        do_reset();
        epsilon = 16'hFFFF;
        run_explore(4'd10, 0);
        run_explore(4'd14, 0);
        // Backpressure on L=7138; ignored starts leave the LFSR at 389C.
        run_explore(4'd7, 10);
        run_explore(4'd3, 0);
        run_explore(4'd1, 0);   // 1C4E
        run_explore(4'd1, 0);   // 0E27: zero nibble forced to action 1
        // L == epsilon (B313) must exploit, not explore.
        epsilon = 16'hB313;
        run_exploit(4'd4, 16'h0080);
        // L = ED89 just below epsilon explores.
        epsilon = 16'hED8A;
        run_explore(4'd14, 0);

        // Reset during SCAN aborts with no result; LFSR reseeds.
        epsilon = 16'h0000;
        pulse_start();
        repeat (7) @(negedge clk);
        chk("mid_rd_act", q_rd_action, 8);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) nvalid++;
        end
        chk("abort_no_valid", nvalid, 0);
        epsilon = 16'hFFFF;
        run_explore(4'd10, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
